// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: sequences a shared 16-bit ALU through shift-add multiply and restoring divide
module alu_muldiv_seq #(
    parameter logic [2:0] OP_ADD = 3'b010,
    parameter int         WIDTH  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_div,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    output logic             alu_bnegate,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    // acc/mq/m double as rem/q/d during a divide
    logic [WIDTH-1:0] acc, mq, m, acc_nx, mq_nx, partial;
    logic ok, last;
    always_comb begin
        partial     = {acc[WIDTH-2:0], mq[WIDTH-1]};
        ok          = acc[WIDTH-1] | alu_carry;
        last        = cnt == LAST;
        alu_a       = state == MUL ? acc : state == DIV ? partial : '0;
        alu_b       = state == MUL ? (mq[0] ? m : '0) : state == DIV ? m : '0;
        alu_op      = OP_ADD;
        alu_bnegate = state == DIV;
        acc_nx      = state == MUL ? {alu_carry, alu_result[WIDTH-1:1]} : state == DIV ? (ok ? alu_result : partial) : acc;
        mq_nx       = state == MUL ? {alu_result[0], mq[WIDTH-1:1]} : state == DIV ? {mq[WIDTH-2:0], ok} : mq;
        busy        = state != IDLE;
        done        = state == DONE;
        state_nx    = state;
        case (state)
            IDLE:    state_nx = !start ? IDLE : !op_div ? MUL : opb == '0 ? DONE : DIV;
            MUL,
            DIV:     state_nx = last ? DONE : state;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            acc         <= '0;
            mq          <= '0;
            m           <= '0;
            result_hi   <= '0;
            result_lo   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                cnt         <= '0;
                div_by_zero <= op_div && opb == '0;
                if (op_div && opb == '0) begin
                    result_lo <= '1;
                    result_hi <= opa;
                end else begin
                    acc <= '0;
                    mq  <= opa;
                    m   <= opb;
                end
            end else if (state == MUL || state == DIV) begin
                cnt <= cnt + 1'b1;
                acc <= acc_nx;
                mq  <= mq_nx;
                if (last) begin
                    result_hi <= acc_nx;
                    result_lo <= mq_nx;
                end
            end
        end
    end
endmodule
